// File: rtl/dot_matrix_scan_pkg.sv
// Shared definitions for the TTT dot-matrix panel: geometry, board cell encoding, scan states.
package dot_matrix_scan_pkg;

  localparam int unsigned DotRows = 14;
  localparam int unsigned DotCols = 10;
  localparam int unsigned RowIdxW = 4;

  typedef enum logic [1:0] {
    CellEmpty = 2'd0,
    CellX     = 2'd1,
    CellO     = 2'd2
  } cell_e;

  typedef enum logic {
    StBlank = 1'b0,
    StDrive = 1'b1
  } scan_state_e;

  // Wide enough to hold the larger of the two phase lengths minus one, never zero bits.
  function automatic int unsigned timer_width(int unsigned dwell, int unsigned blank);
    int unsigned m;
    m = (dwell > blank) ? dwell : blank;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dot_matrix_scan_timer.sv
// Loadable down-counter shared by the BLANK and DWELL phases; tc_o is high while the count is zero.
module scan_timer
  import dot_matrix_scan_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/dot_matrix_scan.sv
// Row-multiplexed dot-matrix driver with double-buffered frame store and tear-free swap.
module dot_matrix_scan
  import dot_matrix_scan_pkg::*;
#(
  parameter int unsigned Rows        = DotRows,
  parameter int unsigned Cols        = DotCols,
  parameter int unsigned DwellCycles = 1000,
  parameter int unsigned BlankCycles = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [RowIdxW-1:0] wr_row_i,
  input  logic [Cols-1:0]    wr_data_i,
  output logic               wr_ready_o,
  input  logic               swap_req_i,
  output logic               swap_done_o,
  output logic               frame_start_o,
  output logic [Rows-1:0]    dot_row_o,
  output logic [Cols-1:0]    dot_col_o
);

  localparam int unsigned TimerW = timer_width(DwellCycles, BlankCycles);
  localparam logic [TimerW-1:0]  DwellLoad = TimerW'(DwellCycles - 1);
  localparam logic [TimerW-1:0]  BlankLoad = TimerW'(BlankCycles - 1);
  localparam logic [RowIdxW-1:0] RowLast   = RowIdxW'(Rows - 1);

  scan_state_e        state_q;
  logic               started_q;
  logic               front_q;
  logic               pending_q;
  logic [RowIdxW-1:0] row_q;
  logic [Cols-1:0]    buf_q [2][Rows];
  logic               wr_ready_q;
  logic               swap_done_q;
  logic               frame_start_q;
  logic [Rows-1:0]    dot_row_q;
  logic [Cols-1:0]    dot_col_q;

  logic              tc;
  logic              tmr_load;
  logic [TimerW-1:0] tmr_val;

  // The first cycle out of reset only arms the row-0 BLANK phase.
  always_comb begin
    tmr_load = !started_q || tc;
    tmr_val  = (started_q && state_q == StBlank) ? DwellLoad : BlankLoad;
  end

  scan_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tc_o      (tc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StBlank;
      started_q     <= 1'b0;
      front_q       <= 1'b0;
      pending_q     <= 1'b0;
      row_q         <= '0;
      wr_ready_q    <= 1'b1;
      swap_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      dot_row_q     <= '0;
      dot_col_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < Rows; r++) begin
          buf_q[b][r] <= '0;
        end
      end
    end else begin
      frame_start_q <= 1'b0;
      swap_done_q   <= 1'b0;

      if (wr_en_i && wr_ready_q && wr_row_i <= RowLast) begin
        buf_q[~front_q][wr_row_i] <= wr_data_i;
      end
      if (swap_req_i && !pending_q) begin
        pending_q  <= 1'b1;
        wr_ready_q <= 1'b0;
      end

      if (!started_q) begin
        started_q     <= 1'b1;
        frame_start_q <= 1'b1;
      end else if (tc) begin
        unique case (state_q)
          StBlank: begin
            state_q   <= StDrive;
            dot_row_q <= Rows'(1) << row_q;
            dot_col_q <= buf_q[front_q][row_q];
          end
          StDrive: begin
            state_q   <= StBlank;
            dot_row_q <= '0;
            dot_col_q <= '0;
            if (row_q == RowLast) begin
              row_q         <= '0;
              frame_start_q <= 1'b1;
              // Swap only at the frame boundary so a frame never mixes two buffers.
              if (pending_q) begin
                front_q     <= ~front_q;
                pending_q   <= 1'b0;
                wr_ready_q  <= 1'b1;
                swap_done_q <= 1'b1;
              end
            end else begin
              row_q <= row_q + RowIdxW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_ready_o    = wr_ready_q;
  assign swap_done_o   = swap_done_q;
  assign frame_start_o = frame_start_q;
  assign dot_row_o     = dot_row_q;
  assign dot_col_o     = dot_col_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Bench for dot_matrix_scan: frame-position model checked every cycle plus directed scenarios.
module tb_dot_matrix_scan;

  localparam int Rows  = 14;
  localparam int Cols  = 10;
  localparam int Dwell = 4;
  localparam int Blank = 2;
  localparam int Slot  = Blank + Dwell;
  localparam int Frame = Rows * Slot;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            wr_en_i = 1'b0;
  logic [3:0]      wr_row_i = '0;
  logic [Cols-1:0] wr_data_i = '0;
  logic            swap_req_i = 1'b0;
  logic            wr_ready_o, swap_done_o, frame_start_o;
  logic [Rows-1:0] dot_row_o;
  logic [Cols-1:0] dot_col_o;

  dot_matrix_scan #(
    .Rows       (Rows),
    .Cols       (Cols),
    .DwellCycles(Dwell),
    .BlankCycles(Blank)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (wr_en_i),
    .wr_row_i     (wr_row_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .swap_req_i   (swap_req_i),
    .swap_done_o  (swap_done_o),
    .frame_start_o(frame_start_o),
    .dot_row_o    (dot_row_o),
    .dot_col_o    (dot_col_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int t = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (t=%0d)", name, act, exp, t);
  endtask

  // Model: frame buffers, front select, pending flag; outputs derived from position in the frame.
  logic [Cols-1:0] m_buf [2][Rows];
  int              m_front;
  bit              m_pending, m_swapped, m_valid, was;
  int              p, row, off;
  logic [Rows-1:0] er;
  logic [Cols-1:0] ec;

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        for (int b = 0; b < 2; b++) for (int r = 0; r < Rows; r++) m_buf[b][r] = '0;
        m_front = 0; m_pending = 0; m_swapped = 0; m_valid = 1; t = -1;
      end else if (m_valid) begin
        was = m_pending;
        m_swapped = 0;
        if (wr_en_i && !was && int'(wr_row_i) < Rows) m_buf[1-m_front][wr_row_i] = wr_data_i;
        if (t >= 0 && t % Frame == Frame - 1 && was) begin
          m_front = 1 - m_front; m_pending = 0; m_swapped = 1;
        end
        if (swap_req_i && !was) m_pending = 1;
        t++;
      end
      @(negedge clk_i);
      if (m_valid) begin
        er = '0; ec = '0;
        if (t >= 0) begin
          p = t % Frame; row = p / Slot; off = p % Slot;
          if (off >= Blank) begin
            er = Rows'(1) << row;
            ec = m_buf[m_front][row];
          end
        end
        check("dot_row", dot_row_o, er);
        check("dot_col", dot_col_o, ec);
        check("frame_start", frame_start_o, (t >= 0 && p == 0));
        check("swap_done", swap_done_o, m_swapped);
        check("wr_ready", wr_ready_o, !m_pending);
        check("onehot0", $onehot0(dot_row_o), 1);
        check("col_off_in_blank", (dot_row_o == '0 && dot_col_o != '0), 0);
      end
    end
  end

  task automatic wait_swap_done(output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (swap_done_o !== 1'b1 && n < 300);
    check("swap_done_seen", swap_done_o, 1);
  endtask

  // Scans one frame starting at the current cycle.
  task automatic frame_scan(input logic [Rows-1:0] r, input logic [Cols-1:0] c,
                            output int n_match, output int n_lit);
    n_match = 0; n_lit = 0;
    for (int i = 0; i < Frame; i++) begin
      if (dot_row_o == r && dot_col_o == c) n_match++;
      if (dot_col_o != '0) n_lit++;
      @(negedge clk_i);
    end
  endtask

  task automatic write_row(input int r, input logic [Cols-1:0] d, input bit swap);
    wr_en_i = 1'b1; wr_row_i = 4'(r); wr_data_i = d; swap_req_i = swap;
    @(negedge clk_i);
    wr_en_i = 1'b0; swap_req_i = 1'b0;
  endtask

  int n, nm, nl, pulses;

  initial begin
    // 1: reset and empty first frame
    repeat (3) @(negedge clk_i);
    check("rst_row", dot_row_o, 0);
    check("rst_col", dot_col_o, 0);
    check("rst_ready", wr_ready_o, 1);
    check("rst_fs", frame_start_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("first_fs", frame_start_o, 1);
    frame_scan('0, '0, nm, nl);
    check("empty_frame_lit", nl, 0);

    // 2: write row 3 together with swap request
    write_row(3, 10'h2A5, 1);
    check("ready_low_pending", wr_ready_o, 0);
    wait_swap_done(n);
    check("swap_with_fs", frame_start_o, 1);
    check("ready_after_swap", wr_ready_o, 1);
    frame_scan(14'h0008, 10'h2A5, nm, nl);
    check("row3_dwell_cycles", nm, 4);

    // 3: write during pending swap is ignored
    write_row(5, 10'h0F0, 1);
    write_row(5, 10'h3C3, 0);
    wait_swap_done(n);
    frame_scan(14'h0020, 10'h0F0, nm, nl);
    check("tear_row5_old", nm, 4);
    frame_scan(14'h0020, 10'h3C3, nm, nl);
    check("tear_row5_new", nm, 0);

    // 4: out-of-range row write
    write_row(14, 10'h3FF, 1);
    wait_swap_done(n);
    frame_scan(14'h0008, 10'h2A5, nm, nl);
    check("oor_row3", nm, 4);
    check("oor_lit", nl, 4);

    // 5: request on the last DWELL cycle of row 13
    n = 0;
    while (!(t >= 0 && t % Frame == Frame - 1) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("found_last_dwell", (n < 200), 1);
    swap_req_i = 1'b1;
    @(negedge clk_i);
    swap_req_i = 1'b0;
    check("late_req_fs", frame_start_o, 1);
    check("late_req_no_swap", swap_done_o, 0);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      swap_req_i = (n == 3);
    end while (swap_done_o !== 1'b1 && n < 300);
    swap_req_i = 1'b0;
    check("late_swap_delay", n, Frame);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (swap_done_o) pulses++;
    end
    check("single_swap_done", pulses, 0);

    // 6: reset mid-DWELL of row 7 with a swap pending
    write_row(7, 10'h1FF, 1);
    wait_swap_done(n);
    write_row(2, 10'h001, 1);
    n = 0;
    while (!(t >= 0 && t % Frame == 7 * Slot + 3) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("row7_sel", dot_row_o, 14'h0080);
    check("row7_col", dot_col_o, 10'h1FF);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("midrst_row", dot_row_o, 0);
    check("midrst_col", dot_col_o, 0);
    check("midrst_ready", wr_ready_o, 1);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("restart_fs", frame_start_o, 1);
    frame_scan('0, '0, nm, nl);
    check("front_cleared", nl, 0);
    swap_req_i = 1'b1;
    @(negedge clk_i);
    swap_req_i = 1'b0;
    wait_swap_done(n);
    frame_scan('0, '0, nm, nl);
    check("back_cleared", nl, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
